// File: rtl/tt_um_nasser_hadi_pattern_ctrl.sv
// rtl/tt_um_nasser_hadi_pattern_ctrl.sv - programmable serial pattern-match controller
// Host loads pattern/length/limit, runs over strobed serial bits, counts overlapping matches.
module tt_um_nasser_hadi_pattern_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_PAT = 2'b00;
  localparam logic [1:0] OP_LEN = 2'b01;
  localparam logic [1:0] OP_LIM = 2'b10;
  localparam logic [1:0] OP_GO  = 2'b11;
  localparam logic [3:0] FILL_MAX = 4'(PAT_W);

  logic             din, din_valid, cmd_strb;
  logic [1:0]       cmd_op;
  logic             cmd_fire, go_fire;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             cmd_prev_q;
  logic             match_q, match_d;

  logic [PAT_W-1:0] hist_sh;
  logic [3:0]       fill_sh;
  logic [CNT_W-1:0] count_inc;
  logic             hit;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:5]};

  assign din       = ui_in[0];
  assign din_valid = ui_in[1];
  assign cmd_strb  = ui_in[2];
  assign cmd_op    = ui_in[4:3];
  assign cmd_fire  = cmd_strb & ~cmd_prev_q;
  assign go_fire   = cmd_fire && (cmd_op == OP_GO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pat_q      <= PAT_W'(8'b0000_0101);
      len_q      <= 4'd3;
      lim_q      <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cmd_prev_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      lim_q      <= lim_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cmd_prev_q <= cmd_strb;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    lim_d     = lim_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    match_d   = 1'b0;
    hist_sh   = {hist_q[PAT_W-2:0], din};
    fill_sh   = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
    count_inc = count_q + CNT_W'(1);
    // Only the low len bits of history take part; the newest bit lines up with pat[0].
    hit = (fill_sh >= len_q);
    for (int i = 0; i < PAT_W; i++) begin
      if ((4'(i) < len_q) && (hist_sh[i] != pat_q[i])) hit = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_PAT: pat_d = uio_in;
            OP_LEN: len_d = {1'b0, uio_in[2:0]} + 4'd1;
            OP_LIM: lim_d = uio_in;
            default: begin
              state_d = S_RUN;
              hist_d  = '0;
              fill_d  = '0;
              count_d = '0;
              ovf_d   = 1'b0;
            end
          endcase
        end
      end
      S_RUN: begin
        // Abort takes priority over a sample arriving on the same edge.
        if (go_fire) begin
          state_d = S_IDLE;
        end else if (din_valid) begin
          hist_d = hist_sh;
          fill_d = fill_sh;
          if (hit) begin
            match_d = 1'b1;
            if (count_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_inc;
              if ((lim_q != '0) && (count_inc == lim_q)) state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (go_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uo_out  = {2'b00, state_q, ovf_q, (state_q == S_DONE), (state_q == S_RUN), match_q};
  assign uio_out = (state_q == S_DONE) ? count_q : '0;
  assign uio_oe  = (state_q == S_DONE) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_nasser_hadi_pattern_ctrl.sv
// tb/tb_tt_um_nasser_hadi_pattern_ctrl.sv - randomized + directed bench with a bit-history reference model
// Every cycle the pin outputs are compared against the model's expected outputs.
module tb_tt_um_nasser_hadi_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       din, valid, strb;
  logic [1:0] op;

  int n_tests;
  int n_fail;

  // Reference model: state as 0/1/2, received bits kept in a queue.
  int   m_state;
  int   m_len;
  int   m_lim;
  int   m_count;
  bit   m_ovf;
  bit   m_match;
  bit   m_prev;
  bit [7:0] m_pat;
  bit   m_bits[$];

  tt_um_nasser_hadi_pattern_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ui_in = {3'b000, op, strb, valid, din};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 3; m_lim = 0; m_count = 0; m_ovf = 0;
    m_match = 0; m_prev = 0; m_pat = 8'h05;
    m_bits.delete();
  endtask

  task automatic model_step();
    bit fire;
    bit hit;
    m_match = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = strb && !m_prev;
    m_prev = strb;
    if (fire && op == 2'd3) begin
      if (m_state == 0) begin
        m_state = 1; m_count = 0; m_ovf = 0;
        m_bits.delete();
      end else begin
        m_state = 0;
      end
    end else if (fire && m_state == 0) begin
      case (op)
        2'd0: m_pat = uio_in;
        2'd1: m_len = int'(uio_in[2:0]) + 1;
        default: m_lim = uio_in;
      endcase
    end else if (m_state == 1 && valid) begin
      m_bits.push_back(din);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      hit = (m_bits.size() >= m_len);
      for (int j = 0; j < m_len; j++)
        if (hit && m_bits[m_bits.size() - 1 - j] != m_pat[j]) hit = 0;
      if (hit) begin
        m_match = 1;
        if (m_count == 255) m_ovf = 1;
        else m_count++;
        if (m_lim != 0 && m_count == m_lim) m_state = 2;
      end
    end
  endtask

  task automatic step(input logic d, input logic v, input logic s, input logic [1:0] o,
                      input logic [7:0] data);
    logic [7:0] exp_uo;
    din = d; valid = v; strb = s; op = o; uio_in = data;
    @(posedge clk);
    model_step();
    #1;
    exp_uo = {2'b00, 2'(m_state), m_ovf, (m_state == 2), (m_state == 1), m_match};
    chk("uo_out", uo_out, exp_uo);
    chk("uio_out", uio_out, (m_state == 2) ? m_count : 0);
    chk("uio_oe", uio_oe, (m_state == 2) ? 8'hFF : 8'h00);
  endtask

  task automatic cmd(input logic [1:0] o, input logic [7:0] data);
    step(1'b0, 1'b0, 1'b1, o, data);
    step(1'b0, 1'b0, 1'b0, o, data);
  endtask

  task automatic sample(input logic b);
    step(b, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] ro;
    n_tests = 0; n_fail = 0;
    ena = 1'b1;
    din = 0; valid = 0; strb = 0; op = 0; uio_in = 0;
    model_reset();

    // Reset defaults and the built-in 101 pattern
    rst_n = 1'b0;
    gap(); gap();
    rst_n = 1'b1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    cmd(2'd3, 8'h00);
    chk("go_running", uo_out[1], 1'b1);
    sample(1); sample(0); sample(1);
    chk("s1_pulse3", uo_out[0], 1'b1);
    sample(0); sample(1);
    chk("s1_pulse5", uo_out[0], 1'b1);
    cmd(2'd3, 8'h00);
    chk("abort_idle", uo_out[5:4], 2'b00);
    chk("abort_oe", uio_oe, 8'h00);
    cmd(2'd3, 8'h00);
    cmd(2'd3, 8'h00);

    // Configure 1011, limit 2
    cmd(2'd0, 8'h0B); cmd(2'd1, 8'h03); cmd(2'd2, 8'h02); cmd(2'd3, 8'h00);
    sample(1); gap(); sample(0); sample(1); gap(); gap(); sample(1);
    chk("s2_pulse4", uo_out[0], 1'b1);
    sample(0); gap(); sample(1); sample(1);
    chk("s2_done", uo_out[5:4], 2'b10);
    chk("s2_count", uio_out, 8'h02);
    chk("s2_oe", uio_oe, 8'hFF);
    sample(1);
    chk("s2_done_ignores_din", uo_out[0], 1'b0);
    cmd(2'd3, 8'h00);

    // Length 1, overlapping, then saturation
    cmd(2'd1, 8'h00); cmd(2'd0, 8'h01); cmd(2'd2, 8'h00); cmd(2'd3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      sample(1);
      chk("s3_pulse", uo_out[0], 1'b1);
    end
    for (int i = 0; i < 300; i++) sample(1);
    chk("sat_ovf", uo_out[3], 1'b1);
    chk("sat_running", uo_out[1], 1'b1);
    cmd(2'd3, 8'h00);

    // Held strobe fires once; SET ignored in RUN; abort beats a matching sample
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 2'd3, 8'h00);
    chk("held_go_run", uo_out[5:4], 2'b01);
    gap();
    cmd(2'd0, 8'hFF);
    sample(0);
    chk("set_pat_ignored", uo_out[0], 1'b0);
    sample(1);
    chk("pat_still_01", uo_out[0], 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'd3, 8'h00);
    chk("abort_no_pulse", uo_out[0], 1'b0);
    chk("abort_state", uo_out[5:4], 2'b00);
    gap();

    // Reset mid-run, then defaults must detect 101 again
    cmd(2'd1, 8'h01); cmd(2'd0, 8'h05); cmd(2'd3, 8'h00);
    for (int i = 0; i < 7; i++) sample(1'(i % 2 == 0));
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_uio", uio_out, 8'h00);
    cmd(2'd2, 8'h01); cmd(2'd3, 8'h00);
    sample(1); sample(0); sample(1);
    chk("midrst_default_done", uo_out[5:4], 2'b10);
    cmd(2'd3, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ro = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      if (ro == 2'd2) rd = 8'($urandom_range(0, 6));
      if (ro == 2'd1) rd = 8'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), ro, rd);
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
